// File: rtl/caliptra_prim_sec_shadow_reg.sv
// -----------------------------------------------------------------------------
// caliptra_prim_sec_shadow_reg
//
// Purpose:
//   Shadowed security register. A value commits only after two consecutive
//   writes carry identical data. The committed value is stored alongside an
//   inverted shadow copy, and the two are compared every cycle so that a
//   flipped storage flop is detected and reported through a sticky flag.
//
// Ports:
//   clk_i          in   clock
//   rst_ni         in   synchronous reset, active low
//   we_i           in   write strobe, one write per asserted cycle
//   wd_i           in   write data [Width-1:0]
//   rd_i           in   read strobe, restarts the two-write sequence
//   q_o            out  committed value [Width-1:0]
//   qe_o           out  one-cycle pulse after a successful commit
//   phase_o        out  0 = expecting first write, 1 = expecting second write
//   update_err_o   out  one-cycle pulse, second write differed from first
//   storage_err_o  out  sticky committed/shadow mismatch flag
//
// Handshake: we_i is a plain strobe with no back-pressure; every cycle with
// we_i=1 is consumed as one write. rd_i only matters when we_i=0.
// -----------------------------------------------------------------------------

// Storage flop kept in its own module so that the committed value and its
// inverted copy stay as two distinct, unmergeable register banks.
module caliptra_prim_sec_anchor_flop #(
    parameter int unsigned     Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_q <= ResetValue;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

module caliptra_prim_sec_shadow_reg #(
    parameter int unsigned     Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [Width-1:0] wd_i,
    input  logic             rd_i,
    output logic [Width-1:0] q_o,
    output logic             qe_o,
    output logic             phase_o,
    output logic             update_err_o,
    output logic             storage_err_o
);

    localparam logic PhaseIdle   = 1'b0;
    localparam logic PhaseStaged = 1'b1;

    logic             phase_q;
    logic [Width-1:0] staged_q;
    logic [Width-1:0] committed_q;
    logic [Width-1:0] shadow_q;

    logic w_phase_d;
    logic w_commit;
    logic w_mismatch;
    logic w_storage_mismatch;

    logic r_qe;
    logic r_update_err;
    logic r_storage_err;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_q <= PhaseIdle;
        end else begin
            phase_q <= w_phase_d;
        end
    end

    // FSM next state: any write in STAGED ends the sequence, matching or not;
    // a read without a write also abandons the staged value.
    always_comb begin
        w_phase_d = phase_q;
        case (phase_q)
            PhaseIdle: begin
                if (we_i) w_phase_d = PhaseStaged;
            end
            PhaseStaged: begin
                if (we_i || rd_i) w_phase_d = PhaseIdle;
            end
            default: w_phase_d = PhaseIdle;
        endcase
    end

    // FSM outputs: commit is blocked once storage integrity is lost, while the
    // data-mismatch report stays independent of the storage flag.
    always_comb begin
        w_commit   = 1'b0;
        w_mismatch = 1'b0;
        if (phase_q == PhaseStaged && we_i) begin
            if (wd_i == staged_q) begin
                w_commit = !r_storage_err;
            end else begin
                w_mismatch = 1'b1;
            end
        end
    end

    // First write of a pair is captured here; the value is left in place
    // after a read abort because the next first write overwrites it anyway.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            staged_q <= '0;
        end else if (phase_q == PhaseIdle && we_i) begin
            staged_q <= wd_i;
        end
    end

    caliptra_prim_sec_anchor_flop #(
        .Width      (Width),
        .ResetValue (ResetValue)
    ) u_committed (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_commit),
        .d_i    (wd_i),
        .q_o    (committed_q)
    );

    caliptra_prim_sec_anchor_flop #(
        .Width      (Width),
        .ResetValue (~ResetValue)
    ) u_shadow (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_commit),
        .d_i    (~wd_i),
        .q_o    (shadow_q)
    );

    assign w_storage_mismatch = (committed_q != ~shadow_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_qe          <= 1'b0;
            r_update_err  <= 1'b0;
            r_storage_err <= 1'b0;
        end else begin
            r_qe          <= w_commit;
            r_update_err  <= w_mismatch;
            r_storage_err <= r_storage_err | w_storage_mismatch;
        end
    end

    assign q_o           = committed_q;
    assign qe_o          = r_qe;
    assign phase_o       = phase_q;
    assign update_err_o  = r_update_err;
    assign storage_err_o = r_storage_err;

endmodule
